// File: rtl/note_sequencer.sv
// Plays up to eight {cutoff, duration} entries into a clock divider.
// Build with NOTE_GAP_EN defined to insert silent gaps between notes.
module note_sequencer #(
   parameter int unsigned TICK_CYCLES = 100000,
   parameter int unsigned GAP_TICKS   = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_m,
   input  logic [15:0] wr_dur,
   input  logic [3:0]  num_notes,
   input  logic        start,
   input  logic        stop,
   output logic [31:0] m,
   output logic        tone_en,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PW = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

   if (TICK_CYCLES < 2 || GAP_TICKS < 1 || GAP_TICKS > 65535) begin : g_param_check
      $error("note_sequencer: parameter out of range");
   end

`ifdef NOTE_GAP_EN
   localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
   typedef enum logic [1:0] {IDLE, PLAY, GAP, FINISH} state_t;
`else
   typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;
`endif

   state_t state;

   logic [31:0] tab_m   [8];
   logic [15:0] tab_dur [8];

   logic [3:0]    count;
   logic [2:0]    idx;
   logic [PW-1:0] presc;
   logic [15:0]   dcnt;
   logic [15:0]   dur_end;

   logic       tick_end;
   logic       last_note;
   logic [2:0] next_idx;
   logic [3:0] clamped;

   // a zero duration still plays one full tick
   function automatic logic [15:0] last_tick(input logic [15:0] d);
      return (d == 16'd0) ? 16'd0 : d - 16'd1;
   endfunction

   assign tick_end  = (presc == PRESC_LAST);
   assign last_note = ({1'b0, idx} == count - 4'd1);
   assign next_idx  = idx + 3'd1;
   assign clamped   = (num_notes > 4'd8) ? 4'd8 : num_notes;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            tab_m[i]   <= '0;
            tab_dur[i] <= '0;
         end
      end else if (wr_en && !busy) begin
         tab_m[wr_addr]   <= wr_m;
         tab_dur[wr_addr] <= wr_dur;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         idx     <= '0;
         presc   <= '0;
         dcnt    <= '0;
         dur_end <= '0;
         m       <= '0;
         tone_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!stop && start) begin
                  if (num_notes == 4'd0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state   <= PLAY;
                     count   <= clamped;
                     idx     <= '0;
                     presc   <= '0;
                     dcnt    <= '0;
                     m       <= tab_m[0];
                     dur_end <= last_tick(tab_dur[0]);
                     tone_en <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
            end

            PLAY: begin
               if (stop) begin
                  state   <= IDLE;
                  presc   <= '0;
                  dcnt    <= '0;
                  tone_en <= 1'b0;
                  busy    <= 1'b0;
               end else if (!tick_end) begin
                  presc <= presc + PW'(1);
               end else begin
                  presc <= '0;
                  if (dcnt != dur_end) begin
                     dcnt <= dcnt + 16'd1;
                  end else if (last_note) begin
                     state   <= FINISH;
                     dcnt    <= '0;
                     tone_en <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     idx  <= next_idx;
                     dcnt <= '0;
`ifdef NOTE_GAP_EN
                     state   <= GAP;
                     tone_en <= 1'b0;
`else
                     m       <= tab_m[next_idx];
                     dur_end <= last_tick(tab_dur[next_idx]);
`endif
                  end
               end
            end

`ifdef NOTE_GAP_EN
            GAP: begin
               if (stop) begin
                  state <= IDLE;
                  presc <= '0;
                  dcnt  <= '0;
                  busy  <= 1'b0;
               end else if (!tick_end) begin
                  presc <= presc + PW'(1);
               end else begin
                  presc <= '0;
                  if (dcnt != GAP_LAST) begin
                     dcnt <= dcnt + 16'd1;
                  end else begin
                     state   <= PLAY;
                     dcnt    <= '0;
                     m       <= tab_m[idx];
                     dur_end <= last_tick(tab_dur[idx]);
                     tone_en <= 1'b1;
                  end
               end
            end
`endif

            FINISH: begin
               state <= IDLE;
            end

            default: begin
               state   <= IDLE;
               tone_en <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_CYCLES=4, GAP_TICKS=2.
module tb_note_sequencer;

`ifdef NOTE_GAP_EN
   localparam int G = 8;
`else
   localparam int G = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [31:0] wr_m = '0;
   logic [15:0] wr_dur = '0;
   logic [3:0]  num_notes = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] m;
   logic        tone_en;
   logic        busy;
   logic        done;

   int tests  = 0;
   int failed = 0;

   note_sequencer #(.TICK_CYCLES(4), .GAP_TICKS(2)) dut (
      .clock(clock), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_m(wr_m), .wr_dur(wr_dur),
      .num_notes(num_notes), .start(start), .stop(stop),
      .m(m), .tone_en(tone_en), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] m0;
      logic [15:0] d0;
      logic [31:0] m1;
      logic [15:0] d1;
      logic [3:0]  n;
      int          c0;
      int          c1;
      int          cb;
      int          cg;
      int          cd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic write_entry(input logic [2:0] a, input logic [31:0] mv, input logic [15:0] dv);
      @(negedge clock);
      wr_en = 1'b1; wr_addr = a; wr_m = mv; wr_dur = dv;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   task automatic play(input logic [3:0] n, input logic [31:0] m0, input logic [31:0] m1,
                       input int inj_w, input int inj_s,
                       output int c0, output int c1, output int cb,
                       output int cg, output int cd, output int dat);
      c0 = 0; c1 = 0; cb = 0; cg = 0; cd = 0; dat = 0;
      @(negedge clock);
      num_notes = n; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         if (tone_en && m == m0) c0++;
         if (tone_en && m == m1) c1++;
         if (busy) cb++;
         if (busy && !tone_en) cg++;
         if (done) begin cd++; dat = k; end
         if (done && busy) cd += 100;
         wr_en = (k == inj_w);
         if (k == inj_w) begin wr_addr = 3'd1; wr_m = 32'd99; wr_dur = 16'd5; end
         start = (k == inj_s);
         if (k == inj_s) num_notes = 4'd1;
         if (dat != 0 && k >= dat + 3) break;
         @(negedge clock);
      end
      wr_en = 1'b0; start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, cb, cg, cd, dat;

      vecs[0] = '{32'd10, 16'd3, 32'd20, 16'd2, 4'd2,  12, 8, 20 + G,     G,     1};
      vecs[1] = '{32'd7,  16'd0, 32'd9,  16'd1, 4'd2,  4,  4, 8 + G,      G,     1};
      vecs[2] = '{32'd5,  16'd2, 32'd6,  16'd3, 4'd1,  8,  0, 8,          0,     1};
      vecs[3] = '{32'd1,  16'd1, 32'd2,  16'd1, 4'd0,  0,  0, 0,          0,     1};
      vecs[4] = '{32'd3,  16'd1, 32'd4,  16'd1, 4'd12, 4,  4, 32 + 7 * G, 7 * G, 1};
      vecs[5] = '{32'd11, 16'd4, 32'd12, 16'd1, 4'd2,  16, 4, 20 + G,     G,     1};

      repeat (2) @(negedge clock);
      check("rst_m", m, 0);
      check("rst_tone", tone_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_busy", busy, 0);

      for (int i = 0; i < 6; i++) begin
         write_entry(3'd0, vecs[i].m0, vecs[i].d0);
         write_entry(3'd1, vecs[i].m1, vecs[i].d1);
         play(vecs[i].n, vecs[i].m0, vecs[i].m1, 0, 0, c0, c1, cb, cg, cd, dat);
         check($sformatf("v%0d_m0_cycles", i), c0, vecs[i].c0);
         check($sformatf("v%0d_m1_cycles", i), c1, vecs[i].c1);
         check($sformatf("v%0d_busy_cycles", i), cb, vecs[i].cb);
         check($sformatf("v%0d_silent_busy", i), cg, vecs[i].cg);
         check($sformatf("v%0d_done_pulses", i), cd, vecs[i].cd);
         check($sformatf("v%0d_done_at", i), dat, vecs[i].cb + 1);
      end

      // abort on cycle 5 of the first note
      write_entry(3'd0, 32'd10, 16'd3);
      write_entry(3'd1, 32'd20, 16'd2);
      @(negedge clock);
      num_notes = 4'd2; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      check("pre_stop_tone", tone_en, 1);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      check("stop_tone", tone_en, 0);
      check("stop_busy", busy, 0);
      check("stop_m_held", m, 10);
      cd = 0;
      repeat (4) begin if (done) cd++; @(negedge clock); end
      check("stop_no_done", cd, 0);

      // abort in the second note, then restart from entry 0
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (13 + G) @(negedge clock);
      check("note2_m", m, 20);
      check("note2_tone", tone_en, 1);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      check("stop2_tone", tone_en, 0);
      check("stop2_m_held", m, 20);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("restart_m", m, 10);
      check("restart_busy", busy, 1);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      check("stop3_busy", busy, 0);

      // stop and start together in IDLE
      stop = 1'b1; start = 1'b1;
      @(negedge clock);
      stop = 1'b0; start = 1'b0;
      check("stopstart_busy", busy, 0);
      check("stopstart_tone", tone_en, 0);
      check("stopstart_done", done, 0);

      // asynchronous reset mid-note
      @(negedge clock);
      num_notes = 4'd2; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("prerst_tone", tone_en, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_m", m, 0);
      check("arst_tone", tone_en, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(negedge clock);
      reset = 1'b0;
      cd = 0;
      repeat (6) begin @(negedge clock); if (done) cd++; end
      check("arst_no_done", cd, 0);

      // entry 1 was cleared by reset; the busy write and start must be ignored
      write_entry(3'd0, 32'd30, 16'd2);
      play(4'd2, 32'd30, 32'd0, 2, 3, c0, c1, cb, cg, cd, dat);
      check("busyw_m0_cycles", c0, 8);
      check("busyw_cleared_entry", c1, 4);
      check("busyw_busy_cycles", cb, 12 + G);
      check("busyw_done_pulses", cd, 1);
      check("busyw_done_at", dat, 13 + G);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000, giving clock cycles per duration tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter GAP_TICKS, default 20, giving silence ticks inserted between notes when NOTE_GAP_EN is defined; legal range 1..65535.
REQ-003 SHALL have port clock  in  1, the single rising-edge clock for all logic.
REQ-004 SHALL have port reset  in  1, asynchronous and active-high.
REQ-005 SHALL have port wr_en  in  1, a table write strobe.
REQ-006 SHALL have port wr_addr  in  3, the table entry index 0..7.
REQ-007 SHALL have port wr_m  in  32, the divider cutoff value for the entry.
REQ-008 SHALL have port wr_dur  in  16, the note duration in ticks.
REQ-009 SHALL have port num_notes  in  4, the number of entries to play (0..8); it is sampled at start.
REQ-010 SHALL have port start  in  1, a single-cycle request to play.
REQ-011 SHALL have port stop  in  1, an abort request.
REQ-012 SHALL have port m  out  32, the cutoff value driven to the clock divider.
REQ-013 SHALL have port tone_en  out  1, which is high while a note sounds and gates the divider output downstream.
REQ-014 SHALL have port busy  out  1, which is high from the accepted start until finish or abort.
REQ-015 SHALL have port done  out  1, a one-cycle pulse on normal completion.

Function
REQ-016 SHALL hold an 8-entry table of {m[31:0], dur[15:0]}, written on a clock edge when wr_en=1 and busy=0. Writes are ignored while busy=1.
REQ-017 SHALL implement the states IDLE, PLAY, GAP, and FINISH, all registered.
REQ-018 IDLE: if start=1 and num_notes is in 1..8, the block SHALL latch the note count, set index=0, and go to PLAY on the next edge with m=table[0].m, tone_en=1, and busy=1.
REQ-019 IDLE: if start=1 and num_notes=0, the block SHALL go to FINISH without sounding. If num_notes>8, it SHALL clamp the value to 8.
REQ-020 PLAY SHALL last exactly max(dur,1)*TICK_CYCLES clock cycles. The tick prescaler and the duration counter are both cleared on PLAY entry.
REQ-021 At the end of PLAY, if index<count-1 the block SHALL increment index and either enter GAP (macro defined) or re-enter PLAY with the next entry (macro undefined). There SHALL be no dead cycle between notes in either path.
REQ-022 At the end of PLAY with index=count-1, the block SHALL go to FINISH with tone_en=0.
REQ-023 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE. done and busy are never high together.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 stop=1 in any state other than IDLE SHALL make the block go to IDLE on the next edge: tone_en=0, busy=0, no done pulse, m held at its last value.
REQ-026 stop=1 and start=1 in the same IDLE cycle SHALL leave the block in IDLE, because stop wins.
REQ-027 m SHALL change only on PLAY entry and SHALL otherwise hold its value, so the divider never sees a mid-note change.
REQ-028 The prescaler SHALL wrap from TICK_CYCLES-1 to 0. The duration counter is 16-bit and compares against the latched dur; it SHALL NOT wrap inside a note.

Reset
REQ-029 On reset assertion, the block SHALL enter IDLE immediately, independent of clock.
REQ-030 Reset values SHALL be: m=0, tone_en=0, busy=0, done=0, all counters 0, all table entries 0.
REQ-031 Reset mid-note SHALL drop tone_en in the same cycle, and no done pulse SHALL follow.

Configuration
REQ-032 Macro NOTE_GAP_EN defined: between consecutive notes the block SHALL enter GAP for GAP_TICKS*TICK_CYCLES cycles with tone_en=0 and m held. stop in GAP behaves as in REQ-025.
REQ-033 Macro NOTE_GAP_EN undefined: GAP SHALL not exist, and notes SHALL play back-to-back with tone_en continuously high across the note boundary.

Verification (TICK_CYCLES=4, GAP_TICKS=2 for simulation)
REQ-034 Write entries {m=10,dur=3},{m=20,dur=2}, num_notes=2, pulse start -> without the macro, tone_en high for 20 cycles with m=10 for 12 cycles then m=20 for 8 cycles; one done pulse after that; busy high for 20 cycles.
REQ-035 Same stimulus with NOTE_GAP_EN defined -> m=10 for 12 cycles, tone_en low for 8 cycles, m=20 for 8 cycles, then done; busy high for 28 cycles.
REQ-036 start with num_notes=0 -> tone_en never rises, busy never rises, done pulses on the following cycle.
REQ-037 stop asserted on cycle 5 of a 12-cycle note -> tone_en=0 and busy=0 on the next edge, no done pulse; a new start then plays from entry 0.
REQ-038 Assert reset mid-note, then assert wr_en with wr_addr=1 while busy, then start while busy -> reset clears all outputs asynchronously, the busy-time write leaves the table unchanged, and the busy-time start is ignored.
REQ-039 Entry with dur=0 -> the note lasts 1 tick (4 cycles).
